mem_port_arbiter: RTL and testbench

Arbitrates the single byte-wide memory port between the multicycle CPU (instruction fetch plus LB/SB) and a secondary DMA/boot-loader requester.

- The CPU has priority.
- A 4-byte instruction fetch is held uninterruptible through a lock input.
- A saturating wait counter guarantees the DMA side forward progress.
- The block sits between the CPU datapath's memory address/data mux and the memory array. The controller stalls while its request is not granted.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_arb_wait_cnt.sv | 31 +++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/DMA memory port arbiter: owner encoding and
// the default starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  localparam int MAXWAIT_DEF = 4;
  localparam int WAIT_W      = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte-wide memory.
// slave is the arbiter's view; master is the surrounding requesters + memory.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_lock;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, dma_gnt, dma_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, dma_gnt, dma_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Saturating count of cycles a DMA request has been kept waiting; the
// saturated flag lets DMA preempt an unlocked CPU owner.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic saturated
);

  localparam logic [WAIT_W-1:0] MAXV = WAIT_W'(MAXWAIT);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  assign saturated = (cnt == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Byte-wide memory port arbiter: CPU priority, fetch lock, DMA starvation guard.
//   state    | meaning
//   OWN_NONE | port idle, address/data muxed to zero
//   OWN_CPU  | CPU owns the port; cpu_gnt follows cpu_req
//   OWN_DMA  | DMA owns the port; dma_gnt follows dma_req
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus,
  output logic [1:0]             owner
);

  owner_e        owner_q;
  logic          wait_sat;
  logic          cpu_gnt_c;
  logic          dma_gnt_c;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  mem_arb_wait_cnt #(
    .MAXWAIT (MAXWAIT)
  ) u_wait_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     ((owner_q == OWN_DMA) || !bus.dma_req),
    .inc       (bus.dma_req),
    .saturated (wait_sat)
  );

  // Lock is only honoured while the CPU already owns the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      case (owner_q)
        OWN_NONE: begin
          if (bus.cpu_req)      owner_q <= OWN_CPU;
          else if (bus.dma_req) owner_q <= OWN_DMA;
          else                  owner_q <= OWN_NONE;
        end
        OWN_CPU: begin
          if (bus.cpu_lock)                                    owner_q <= OWN_CPU;
          else if (bus.dma_req && (!bus.cpu_req || wait_sat))  owner_q <= OWN_DMA;
          else if (bus.cpu_req)                                owner_q <= OWN_CPU;
          else                                                 owner_q <= OWN_NONE;
        end
        OWN_DMA: begin
          if (bus.cpu_req)      owner_q <= OWN_CPU;
          else if (bus.dma_req) owner_q <= OWN_DMA;
          else                  owner_q <= OWN_NONE;
        end
        default: owner_q <= OWN_NONE;
      endcase
    end
  end

  assign cpu_gnt_c = (owner_q == OWN_CPU) && bus.cpu_req;
  assign dma_gnt_c = (owner_q == OWN_DMA) && bus.dma_req;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    case (owner_q)
      OWN_CPU: begin
        addr_mux  = bus.cpu_addr;
        wdata_mux = bus.cpu_wdata;
      end
      OWN_DMA: begin
        addr_mux  = bus.dma_addr;
        wdata_mux = bus.dma_wdata;
      end
      default: begin
        addr_mux  = '0;
        wdata_mux = '0;
      end
    endcase
  end

  // Write strobe is gated by the grant, so an async reset kills it at once.
  assign bus.mem_we    = (cpu_gnt_c && bus.cpu_we) || (dma_gnt_c && bus.dma_we);
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.dma_gnt   = dma_gnt_c;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle reference model check plus directed
// scenarios with hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] owner;

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus();

  mem_port_arbiter #(.AW(8), .DW(8), .MAXWAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int we_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  // Memory array seen by the DUT
  bit [7:0] tbmem [256];
  bit       tbwr  [256];
  assign bus.mem_rdata = tbwr[bus.mem_addr] ? tbmem[bus.mem_addr] : init_val(bus.mem_addr);
  always @(posedge clk) begin
    if (bus.mem_we) begin
      tbmem[bus.mem_addr] <= bus.mem_wdata;
      tbwr[bus.mem_addr]  <= 1'b1;
    end
    if (!reset && bus.mem_we) we_cnt++;
  end

  // Reference model: owner as 0/1/2, age = cycles DMA has waited unserved
  bit [7:0] shadow [256];
  bit       sh_wr  [256];
  int m_owner = 0;
  int m_age = 0;

  function automatic logic [7:0] sh_rd(input logic [7:0] a);
    return sh_wr[a] ? shadow[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    bit e_cg, e_dg, e_we;
    logic [7:0] e_addr, e_wd;
    int nxt;
    if (reset) begin
      m_owner = 0;
      m_age = 0;
      chk("rst_owner", {30'd0, owner}, 0);
      chk("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
      chk("rst_dma_gnt", {31'd0, bus.dma_gnt}, 0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 0);
      chk("rst_mem_addr", {24'd0, bus.mem_addr}, 0);
      chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 0);
    end else begin
      e_cg = (m_owner == 1) && bus.cpu_req;
      e_dg = (m_owner == 2) && bus.dma_req;
      e_addr = (m_owner == 1) ? bus.cpu_addr : (m_owner == 2) ? bus.dma_addr : 8'h00;
      e_wd   = (m_owner == 1) ? bus.cpu_wdata : (m_owner == 2) ? bus.dma_wdata : 8'h00;
      e_we = (e_cg && bus.cpu_we) || (e_dg && bus.dma_we);
      chk("owner", {30'd0, owner}, m_owner);
      chk("cpu_gnt", {31'd0, bus.cpu_gnt}, {31'd0, e_cg});
      chk("dma_gnt", {31'd0, bus.dma_gnt}, {31'd0, e_dg});
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e_we});
      chk("mem_addr", {24'd0, bus.mem_addr}, {24'd0, e_addr});
      chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e_wd});
      if (e_cg && !bus.cpu_we) chk("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, sh_rd(e_addr)});
      if (e_dg && !bus.dma_we) chk("dma_rdata", {24'd0, bus.dma_rdata}, {24'd0, sh_rd(e_addr)});
      if (e_we) begin
        shadow[e_addr] = e_wd;
        sh_wr[e_addr]  = 1'b1;
      end
      case (m_owner)
        0: nxt = bus.cpu_req ? 1 : (bus.dma_req ? 2 : 0);
        1: begin
          if (bus.cpu_lock) nxt = 1;
          else if (bus.dma_req && (!bus.cpu_req || m_age >= MW)) nxt = 2;
          else nxt = bus.cpu_req ? 1 : 0;
        end
        default: nxt = bus.cpu_req ? 1 : (bus.dma_req ? 2 : 0);
      endcase
      m_age = (m_owner == 2 || !bus.dma_req) ? 0 : m_age + 1;
      m_owner = nxt;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_acc(input bit we, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    #1;
    lat = 0;
    while (!bus.cpu_gnt && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    rd = bus.cpu_rdata;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  // Both request from idle; lock held in cycles 1..lock_n; DMA drops after its grant
  task automatic run_fetch(input int lock_n, output logic [9:0] cg, output logic [9:0] dg);
    cg = '0; dg = '0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_we = 1'b0;
    bus.dma_req = 1'b1; bus.dma_addr = 8'h40; bus.dma_we = 1'b0;
    bus.cpu_lock = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      cg[k] = bus.cpu_gnt;
      dg[k] = bus.dma_gnt;
      @(posedge clk); #1;
      if (dg[k]) bus.dma_req = 1'b0;
      bus.cpu_lock = (k + 1 <= lock_n);
      #1;
    end
    bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0; bus.dma_req = 1'b0;
    idle(3);
  endtask

  initial begin
    logic [7:0] rd;
    logic [9:0] cg, dg;
    int lat, we_base;
    bus.cpu_req = 0; bus.cpu_lock = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    // Single CPU read from idle
    idle(1);
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h10;
    #1;
    chk("t1_c0_gnt", {31'd0, bus.cpu_gnt}, 0);
    @(posedge clk); #2;
    chk("t1_c1_owner", {30'd0, owner}, 1);
    chk("t1_c1_gnt", {31'd0, bus.cpu_gnt}, 1);
    chk("t1_c1_addr", {24'd0, bus.mem_addr}, 32'h10);
    bus.cpu_req = 1'b0;
    idle(2);

    // CPU write then read back
    we_base = we_cnt;
    cpu_acc(1'b1, 8'h20, 8'hA5, rd, lat);
    chk("t2_latency", lat, 1);
    idle(2);
    chk("t2_we_pulses", we_cnt - we_base, 1);
    cpu_acc(1'b0, 8'h20, 8'h00, rd, lat);
    chk("t2_readback", {24'd0, rd}, 32'hA5);
    idle(2);

    // Starvation guard without lock, then fetch lock of 3 and 5 cycles
    run_fetch(0, cg, dg);
    chk("t3_cpu_hist", {22'd0, cg}, 32'b11_1101_1110);
    chk("t3_dma_hist", {22'd0, dg}, 32'b00_0010_0000);
    run_fetch(3, cg, dg);
    chk("t4_lock3_cpu", {22'd0, cg}, 32'b11_1101_1110);
    chk("t4_lock3_dma", {22'd0, dg}, 32'b00_0010_0000);
    run_fetch(5, cg, dg);
    chk("t4_lock5_cpu", {22'd0, cg}, 32'b11_0111_1110);
    chk("t4_lock5_dma", {22'd0, dg}, 32'b00_1000_0000);

    // DMA owns, CPU arrives
    bus.dma_req = 1'b1; bus.dma_addr = 8'h40; bus.dma_we = 1'b0;
    #1;
    chk("t5_c0_dma_gnt", {31'd0, bus.dma_gnt}, 0);
    @(posedge clk); #2;
    chk("t5_c1_owner", {30'd0, owner}, 2);
    chk("t5_c1_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h30;
    #1;
    chk("t5_c2_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    chk("t5_c2_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
    @(posedge clk); #2;
    chk("t5_c3_owner", {30'd0, owner}, 1);
    chk("t5_c3_cpu_gnt", {31'd0, bus.cpu_gnt}, 1);
    chk("t5_c3_dma_gnt", {31'd0, bus.dma_gnt}, 0);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    idle(3);

    // Async reset in the middle of a DMA write grant
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h60; bus.dma_wdata = 8'h99;
    @(posedge clk); #2;
    chk("t6_pre_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    chk("t6_pre_mem_we", {31'd0, bus.mem_we}, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_mem_we", {31'd0, bus.mem_we}, 0);
    chk("t6_dma_gnt", {31'd0, bus.dma_gnt}, 0);
    chk("t6_owner", {30'd0, owner}, 0);
    @(posedge clk); #1;
    chk("t6_mem_unchanged", {24'd0, (tbwr[8'h60] ? tbmem[8'h60] : init_val(8'h60))}, 32'h5C);
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    reset = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
